// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: sole owner of a single-port RAM. Clears every location after reset,
// then shares the port round-robin between requesters A and B with in-order read return.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              init_done
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // One extra counter bit so the sweep can spend a cycle at DEPTH retiring the last write.
  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SWEEP_END = CNT_W'(DEPTH);

  logic [0:0]       state;
  logic [CNT_W-1:0] sweep_cnt;
  logic             last;
  logic             run;

  logic             s1_valid;
  logic             s1_owner;
  logic             s2_valid;
  logic             s2_owner;

  assign run = (state == ST_RUN);

  // On a tie the requester that was not served most recently wins.
  assign a_gnt = run & a_req & (~b_req | (last == OWNER_B));
  assign b_gnt = run & b_req & (~a_req | (last == OWNER_A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= '0;
    end else if (state == ST_INIT) begin
      if (sweep_cnt == SWEEP_END) begin
        ram_we    <= 1'b0;
        init_done <= 1'b1;
        state     <= ST_RUN;
      end else begin
        ram_we    <= 1'b1;
        ram_addr  <= sweep_cnt[ADDR_W-1:0];
        ram_data  <= '0;
        sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
    end else begin
      // Idle cycles leave address/data alone so the RAM just recaptures the same address.
      if (a_gnt) begin
        ram_we   <= a_we;
        ram_addr <= a_addr;
        ram_data <= a_wdata;
      end else if (b_gnt) begin
        ram_we   <= b_we;
        ram_addr <= b_addr;
        ram_data <= b_wdata;
      end else begin
        ram_we   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= OWNER_B;
    end else if (a_gnt) begin
      last <= OWNER_A;
    end else if (b_gnt) begin
      last <= OWNER_B;
    end
  end

  // Two stages match the RAM: command registered, address captured, then data sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_owner <= OWNER_A;
      s2_valid <= 1'b0;
      s2_owner <= OWNER_A;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      s1_valid <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
      s1_owner <= b_gnt ? OWNER_B : OWNER_A;
      s2_valid <= s1_valid;
      s2_owner <= s1_owner;
      a_rvalid <= s2_valid & (s2_owner == OWNER_A);
      b_rvalid <= s2_valid & (s2_owner == OWNER_B);
      if (s2_valid && s2_owner == OWNER_A) a_rdata <= ram_q;
      if (s2_valid && s2_owner == OWNER_B) b_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter with a behavioural 64x8 RAM
// whose contents start as 0xEE so the clear sweep is observable.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic       init_done;

  int total;
  int passed;
  int a_idx;
  int b_idx;

  ram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_q(ram_q), .init_done(init_done)
  );

  // Single-port RAM with a registered read address that write edges leave untouched.
  logic [7:0] mem [0:63];
  logic [5:0] ram_areg;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    else        ram_areg      <= ram_addr;
  end

  assign ram_q = mem[ram_areg];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ar, input logic aw, input logic [5:0] aa,
                               input logic [7:0] ad, input logic br, input logic bw,
                               input logic [5:0] ba, input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Called right after reset release: checks all 64 sweep writes and the init_done edge.
  task automatic runSweep(input string tag);
    for (int k = 1; k <= 64; k++) begin
      checkOutput({tag, " a_gnt"}, a_gnt, 0);
      checkOutput({tag, " b_gnt"}, b_gnt, 0);
      tick;
      checkOutput({tag, " ram_we"}, ram_we, 1);
      checkOutput({tag, " ram_addr"}, ram_addr, k - 1);
      checkOutput({tag, " ram_data"}, ram_data, 0);
      checkOutput({tag, " init_done low"}, init_done, 0);
      checkOutput({tag, " a_rvalid"}, a_rvalid, 0);
      checkOutput({tag, " b_rvalid"}, b_rvalid, 0);
    end
    checkOutput({tag, " a_gnt edge65"}, a_gnt, 0);
    checkOutput({tag, " b_gnt edge65"}, b_gnt, 0);
    tick;
    checkOutput({tag, " ram_we edge65"}, ram_we, 0);
    checkOutput({tag, " init_done edge65"}, init_done, 1);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    applyStimulus(1, 0, 6'd17, 8'h00, 1, 0, 6'd17, 8'h00);

    // Test 1: reset values, clear sweep, then both read address 17
    repeat (3) tick;
    checkOutput("reset ram_we", ram_we, 0);
    checkOutput("reset ram_addr", ram_addr, 0);
    checkOutput("reset ram_data", ram_data, 0);
    checkOutput("reset init_done", init_done, 0);
    checkOutput("reset a_rvalid", a_rvalid, 0);
    checkOutput("reset b_rvalid", b_rvalid, 0);
    checkOutput("reset a_rdata", a_rdata, 0);
    checkOutput("reset b_rdata", b_rdata, 0);
    rst_n = 1'b1;
    #1;
    runSweep("t1 sweep");
    #1;
    checkOutput("t1 tie a_gnt", a_gnt, 1);
    checkOutput("t1 tie b_gnt", b_gnt, 0);
    tick;
    checkOutput("t1 ram_addr", ram_addr, 17);
    applyStimulus(0, 0, 6'd17, 8'h00, 1, 0, 6'd17, 8'h00);
    #1;
    checkOutput("t1 b_gnt", b_gnt, 1);
    tick;
    checkOutput("t1 a_rvalid early", a_rvalid, 0);
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    tick;
    checkOutput("t1 a_rvalid", a_rvalid, 1);
    checkOutput("t1 a_rdata", a_rdata, 8'h00);
    checkOutput("t1 b_rvalid early", b_rvalid, 0);
    tick;
    checkOutput("t1 b_rvalid", b_rvalid, 1);
    checkOutput("t1 b_rdata", b_rdata, 8'h00);
    checkOutput("t1 a_rvalid drop", a_rvalid, 0);

    // Test 2: A writes 0x5A to 5 then reads it back
    applyStimulus(1, 1, 6'd5, 8'h5A, 0, 0, 6'd0, 8'h00);
    #1;
    checkOutput("t2 wr a_gnt", a_gnt, 1);
    tick;
    checkOutput("t2 ram_we", ram_we, 1);
    checkOutput("t2 ram_addr", ram_addr, 5);
    checkOutput("t2 ram_data", ram_data, 8'h5A);
    applyStimulus(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00);
    #1;
    checkOutput("t2 rd a_gnt", a_gnt, 1);
    tick;
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    checkOutput("t2 a_rvalid +0", a_rvalid, 0);
    tick;
    checkOutput("t2 a_rvalid +1", a_rvalid, 0);
    tick;
    checkOutput("t2 a_rvalid +2", a_rvalid, 1);
    checkOutput("t2 a_rdata", a_rdata, 8'h5A);
    checkOutput("t2 b_rvalid", b_rvalid, 0);
    tick;
    checkOutput("t2 a_rvalid pulse", a_rvalid, 0);
    checkOutput("t2 a_rdata hold", a_rdata, 8'h5A);

    // Test 3: B pre-writes 10..12 and 20..22, then A and B contend for six reads
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, (i < 3) ? 6'(10 + i) : 6'(17 + i), 8'(8'h11 * (i + 1)));
      #1;
      checkOutput("t3 prewrite b_gnt", b_gnt, 1);
      tick;
    end
    a_idx = 0;
    b_idx = 0;
    for (int j = 0; j < 8; j++) begin
      applyStimulus(a_idx < 3, 0, 6'(10 + a_idx), 8'h00, b_idx < 3, 0, 6'(20 + b_idx), 8'h00);
      #1;
      checkOutput("t3 a_gnt", a_gnt, (j < 6) && (j % 2 == 0));
      checkOutput("t3 b_gnt", b_gnt, (j < 6) && (j % 2 == 1));
      if (j < 6) begin
        if (j % 2 == 0) a_idx++;
        else            b_idx++;
      end
      tick;
      if (j < 2) begin
        checkOutput("t3 a_rvalid idle", a_rvalid, 0);
        checkOutput("t3 b_rvalid idle", b_rvalid, 0);
      end else if ((j - 2) % 2 == 0) begin
        checkOutput("t3 a_rvalid", a_rvalid, 1);
        checkOutput("t3 b_rvalid quiet", b_rvalid, 0);
        checkOutput("t3 a_rdata", a_rdata, 8'h11 * ((j - 2) / 2 + 1));
      end else begin
        checkOutput("t3 b_rvalid", b_rvalid, 1);
        checkOutput("t3 a_rvalid quiet", a_rvalid, 0);
        checkOutput("t3 b_rdata", b_rdata, 8'h11 * ((j - 3) / 2 + 4));
      end
    end

    // Test 4: B writes 0xC3 to 63, A reads 63 on the very next grant
    applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, 6'd63, 8'hC3);
    #1;
    checkOutput("t4 b_gnt", b_gnt, 1);
    tick;
    applyStimulus(1, 0, 6'd63, 8'h00, 0, 0, 6'd0, 8'h00);
    #1;
    checkOutput("t4 a_gnt", a_gnt, 1);
    tick;
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    tick;
    tick;
    checkOutput("t4 a_rvalid", a_rvalid, 1);
    checkOutput("t4 a_rdata", a_rdata, 8'hC3);

    // Test 5: reset with reads in flight, sweep reruns, address 5 is cleared
    applyStimulus(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00);
    #1;
    checkOutput("t5 a_gnt first", a_gnt, 1);
    tick;
    applyStimulus(1, 0, 6'd12, 8'h00, 1, 0, 6'd10, 8'h00);
    #1;
    checkOutput("t5 b_gnt", b_gnt, 1);
    checkOutput("t5 a_gnt blocked", a_gnt, 0);
    tick;
    #1;
    checkOutput("t5 a_gnt second", a_gnt, 1);
    tick;
    checkOutput("t5 a_rvalid pre", a_rvalid, 1);
    checkOutput("t5 a_rdata pre", a_rdata, 8'h5A);
    checkOutput("t5 b_gnt pre", b_gnt, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 a_rvalid rst", a_rvalid, 0);
    checkOutput("t5 a_rdata rst", a_rdata, 0);
    checkOutput("t5 a_gnt rst", a_gnt, 0);
    checkOutput("t5 b_gnt rst", b_gnt, 0);
    checkOutput("t5 init_done rst", init_done, 0);
    checkOutput("t5 ram_we rst", ram_we, 0);
    tick;
    checkOutput("t5 b_rvalid rst", b_rvalid, 0);
    checkOutput("t5 a_rvalid rst2", a_rvalid, 0);
    applyStimulus(1, 0, 6'd5, 8'h00, 0, 0, 6'd0, 8'h00);
    rst_n = 1'b1;
    #1;
    runSweep("t5 sweep");
    #1;
    checkOutput("t5 a_gnt after", a_gnt, 1);
    tick;
    applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
    tick;
    tick;
    checkOutput("t5 a_rvalid after", a_rvalid, 1);
    checkOutput("t5 a_rdata cleared", a_rdata, 8'h00);

    // Test 6: B alone writes 30..39, then issues ten back-to-back reads
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 6'd0, 8'h00, 1, 1, 6'(30 + i), 8'(8'hA0 + i));
      #1;
      checkOutput("t6 wr b_gnt", b_gnt, 1);
      tick;
    end
    for (int j = 0; j < 12; j++) begin
      if (j < 10) applyStimulus(0, 0, 6'd0, 8'h00, 1, 0, 6'(30 + j), 8'h00);
      else        applyStimulus(0, 0, 6'd0, 8'h00, 0, 0, 6'd0, 8'h00);
      #1;
      checkOutput("t6 rd b_gnt", b_gnt, j < 10);
      tick;
      checkOutput("t6 a_rvalid", a_rvalid, 0);
      if (j >= 2) begin
        checkOutput("t6 b_rvalid", b_rvalid, 1);
        checkOutput("t6 b_rdata", b_rdata, 8'hA0 + (j - 2));
      end
    end
    tick;
    checkOutput("t6 b_rvalid end", b_rvalid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
